// File: rtl/dsram_arbiter.sv
// dsram_arbiter
// Shares the single-port data SRAM between the CPU memory pipeline (port 0)
// and an auxiliary requester (port 1). One access is issued per cycle. The
// CPU has priority, but a wait counter forces an aux grant after MAX_WAIT
// consecutive denied aux cycles. Read data returns one cycle after the grant
// and is routed to whichever port issued the read.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flush                        kills the CPU request and CPU read return
//   cpu_req/wen/addr/wdata       CPU request (wen==0 means read)
//   cpu_gnt, cpu_stallreq        CPU grant / stall request (combinational)
//   cpu_rvalid, cpu_rdata        CPU read return
//   aux_*                        same as the CPU port (no flush, no stall)
//   data_sram_en/wen/addr/wdata  SRAM command port
//   data_sram_rdata              SRAM read data, 1 cycle after a read
module dsram_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stallreq,
  input  logic        aux_req,
  input  logic [3:0]  aux_wen,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [3:0] MAX_W = MAX_WAIT[3:0];

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;
  owner_t     rd_owner_reg;
  owner_t     rd_owner_next;

  logic cpu_req_eff;
  logic force_aux;

  // A flushed CPU request is treated as absent: it neither wins nor stalls.
  assign cpu_req_eff = cpu_req & ~flush;
  assign force_aux   = aux_req & (wait_cnt_reg == MAX_W);
  assign aux_gnt     = aux_req & (force_aux | ~cpu_req_eff);
  assign cpu_gnt     = cpu_req_eff & ~aux_gnt;
  assign cpu_stallreq = cpu_req_eff & ~cpu_gnt;

  // SRAM command mux; everything idles at zero when nobody is granted.
  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0;
    data_sram_addr  = 32'b0;
    data_sram_wdata = 32'b0;
    if (aux_gnt) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = aux_wen;
      data_sram_addr  = aux_addr;
      data_sram_wdata = aux_wdata;
    end else if (cpu_gnt) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = cpu_wen;
      data_sram_addr  = cpu_addr;
      data_sram_wdata = cpu_wdata;
    end
  end

  // Wait counter: counts consecutive denied aux cycles, clears as soon as aux
  // is served or withdraws its request.
  always_comb begin
    wait_cnt_next = 4'd0;
    if (aux_req && !aux_gnt) begin
      if (wait_cnt_reg == MAX_W) wait_cnt_next = MAX_W;
      else                       wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  // Read-return tag: remembers who owns the data arriving next cycle.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (cpu_gnt && (cpu_wen == 4'b0))      rd_owner_next = OWN_CPU;
    else if (aux_gnt && (aux_wen == 4'b0)) rd_owner_next = OWN_AUX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= 4'd0;
      rd_owner_reg <= OWN_NONE;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // Return path: a flush in the return cycle drops only the CPU read.
  assign cpu_rvalid = (rd_owner_reg == OWN_CPU) & ~flush;
  assign aux_rvalid = (rd_owner_reg == OWN_AUX);
  assign cpu_rdata  = cpu_rvalid ? data_sram_rdata : 32'b0;
  assign aux_rdata  = aux_rvalid ? data_sram_rdata : 32'b0;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed testbench for dsram_arbiter (MAX_WAIT = 4). Inputs change on the
// falling edge; outputs are checked 1 time unit later.
module tb_dsram_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        cpu_req;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_stallreq;
  logic        aux_req;
  logic [3:0]  aux_wen;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  int total;
  int bad;

  dsram_arbiter #(.MAX_WAIT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .cpu_req         (cpu_req),
    .cpu_wen         (cpu_wen),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_gnt         (cpu_gnt),
    .cpu_rvalid      (cpu_rvalid),
    .cpu_rdata       (cpu_rdata),
    .cpu_stallreq    (cpu_stallreq),
    .aux_req         (aux_req),
    .aux_wen         (aux_wen),
    .aux_addr        (aux_addr),
    .aux_wdata       (aux_wdata),
    .aux_gnt         (aux_gnt),
    .aux_rvalid      (aux_rvalid),
    .aux_rdata       (aux_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    logic prev_cpu;
    logic prev_aux;
    logic [31:0] exp_rd;
    total = 0;
    bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    cpu_req = 1'b0; cpu_wen = 4'b0; cpu_addr = 32'b0; cpu_wdata = 32'b0;
    aux_req = 1'b0; aux_wen = 4'b0; aux_addr = 32'b0; aux_wdata = 32'b0;
    data_sram_rdata = 32'b0;

    // ---- Reset state
    step; #1;
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_aux_rvalid", aux_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_aux_rdata", aux_rdata, 0);
    check("rst_sram_en", data_sram_en, 0);
    rst = 1'b0;
    $display("txn reset released");

    // ---- Solo CPU read
    step;
    cpu_req = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h8000_1004;
    #1;
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_aux_gnt", aux_gnt, 0);
    check("rd_stall", cpu_stallreq, 0);
    check("rd_sram_en", data_sram_en, 1);
    check("rd_sram_wen", data_sram_wen, 0);
    check("rd_sram_addr", data_sram_addr, 32'h8000_1004);
    $display("txn cpu read addr=%h", cpu_addr);

    // Return cycle, and issue a byte write in the same cycle
    step;
    data_sram_rdata = 32'hDEAD_BEEF;
    cpu_wen = 4'b0011; cpu_addr = 32'h8000_1008; cpu_wdata = 32'hCAFE_F00D;
    #1;
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("rd_aux_rvalid", aux_rvalid, 0);
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_sram_wen", data_sram_wen, 4'b0011);
    check("wr_sram_addr", data_sram_addr, 32'h8000_1008);
    check("wr_sram_wdata", data_sram_wdata, 32'hCAFE_F00D);
    $display("txn cpu write addr=%h data=%h", cpu_addr, cpu_wdata);

    step;
    cpu_req = 1'b0; cpu_wen = 4'b0;
    #1;
    check("wr_no_rvalid", cpu_rvalid, 0);
    check("idle_sram_en", data_sram_en, 0);
    check("idle_sram_addr", data_sram_addr, 0);

    // ---- Contention: both request reads continuously
    prev_cpu = 1'b0;
    prev_aux = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      cpu_req = 1'b1; cpu_addr = 32'h0000_1000;
      aux_req = 1'b1; aux_addr = 32'h0000_2000; aux_wen = 4'b0;
      data_sram_rdata = 32'hA000_0000 + i;
      #1;
      check($sformatf("cont%0d_cpu_gnt", i), cpu_gnt, (i != 4 && i != 9));
      check($sformatf("cont%0d_aux_gnt", i), aux_gnt, (i == 4 || i == 9));
      check($sformatf("cont%0d_stall", i), cpu_stallreq, (i == 4 || i == 9));
      check($sformatf("cont%0d_addr", i), data_sram_addr,
            (i == 4 || i == 9) ? 32'h0000_2000 : 32'h0000_1000);
      check($sformatf("cont%0d_cpu_rvalid", i), cpu_rvalid, prev_cpu);
      check($sformatf("cont%0d_aux_rvalid", i), aux_rvalid, prev_aux);
      exp_rd = prev_cpu ? (32'hA000_0000 + i) : 32'b0;
      check($sformatf("cont%0d_cpu_rdata", i), cpu_rdata, exp_rd);
      exp_rd = prev_aux ? (32'hA000_0000 + i) : 32'b0;
      check($sformatf("cont%0d_aux_rdata", i), aux_rdata, exp_rd);
      $display("txn contention cycle %0d cpu_gnt=%0b aux_gnt=%0b", i, cpu_gnt, aux_gnt);
      prev_cpu = (i != 4 && i != 9);
      prev_aux = (i == 4 || i == 9);
    end

    step;
    cpu_req = 1'b0; aux_req = 1'b0; data_sram_rdata = 32'h5555_0000;
    #1;
    check("cont_end_aux_rvalid", aux_rvalid, 1);
    check("cont_end_aux_rdata", aux_rdata, 32'h5555_0000);
    check("cont_end_cpu_rvalid", cpu_rvalid, 0);

    // ---- Alternating reads: CPU at n, aux at n+1
    step;
    cpu_req = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h0000_0010;
    #1;
    check("alt_cpu_gnt", cpu_gnt, 1);
    step;
    cpu_req = 1'b0;
    aux_req = 1'b1; aux_wen = 4'b0; aux_addr = 32'h0000_0020;
    data_sram_rdata = 32'h1111_1111;
    #1;
    check("alt_aux_gnt", aux_gnt, 1);
    check("alt_aux_addr", data_sram_addr, 32'h0000_0020);
    check("alt_cpu_rvalid", cpu_rvalid, 1);
    check("alt_cpu_rdata", cpu_rdata, 32'h1111_1111);
    check("alt_aux_rvalid0", aux_rvalid, 0);
    check("alt_aux_rdata0", aux_rdata, 0);
    step;
    aux_req = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    #1;
    check("alt_aux_rvalid", aux_rvalid, 1);
    check("alt_aux_rdata", aux_rdata, 32'h2222_2222);
    check("alt_cpu_rvalid1", cpu_rvalid, 0);
    check("alt_cpu_rdata1", cpu_rdata, 0);
    $display("txn alternating reads done");

    // ---- Flush: kill CPU return, and kill a new CPU request
    step;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0030;
    #1;
    check("fl_cpu_gnt", cpu_gnt, 1);
    step;
    flush = 1'b1; data_sram_rdata = 32'h3333_3333;
    #1;
    check("fl_cpu_rvalid", cpu_rvalid, 0);
    check("fl_cpu_rdata", cpu_rdata, 0);
    check("fl_req_cpu_gnt", cpu_gnt, 0);
    check("fl_req_stall", cpu_stallreq, 0);
    check("fl_req_sram_en", data_sram_en, 0);
    $display("txn flush with cpu_req");

    // Flush with both requesting: aux wins, its read survives a flush
    step;
    aux_req = 1'b1; aux_wen = 4'b0; aux_addr = 32'h0000_0040;
    #1;
    check("fl_both_aux_gnt", aux_gnt, 1);
    check("fl_both_cpu_gnt", cpu_gnt, 0);
    step;
    aux_req = 1'b0; cpu_req = 1'b0; data_sram_rdata = 32'h4444_4444;
    #1;
    check("fl_aux_rvalid", aux_rvalid, 1);
    check("fl_aux_rdata", aux_rdata, 32'h4444_4444);
    step;
    flush = 1'b0;

    // ---- Aux drop: denied 3 cycles, idle 1, then a full wait again
    for (int i = 0; i < 3; i++) begin
      step;
      cpu_req = 1'b1; aux_req = 1'b1;
      #1;
      check($sformatf("drop_pre%0d_cpu_gnt", i), cpu_gnt, 1);
    end
    step;
    aux_req = 1'b0;
    #1;
    check("drop_gap_cpu_gnt", cpu_gnt, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      aux_req = 1'b1;
      #1;
      check($sformatf("drop_post%0d_aux_gnt", i), aux_gnt, (i == 4));
      check($sformatf("drop_post%0d_cpu_gnt", i), cpu_gnt, (i != 4));
    end
    $display("txn aux drop sequence done");
    step;
    cpu_req = 1'b0; aux_req = 1'b0;

    // ---- Asynchronous reset during a pending CPU read return
    step;
    cpu_req = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h0000_0050;
    #1;
    check("ar_cpu_gnt", cpu_gnt, 1);
    step;
    cpu_req = 1'b0; data_sram_rdata = 32'h6666_6666;
    #1;
    check("ar_pre_rvalid", cpu_rvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_cpu_rvalid", cpu_rvalid, 0);
    check("ar_cpu_rdata", cpu_rdata, 0);
    step;
    rst = 1'b0;
    #1;
    check("ar_idle_sram_en", data_sram_en, 0);
    check("ar_idle_rvalid", cpu_rvalid, 0);
    // After reset wait_cnt is 0: a fresh contention needs 4 denials
    step;
    cpu_req = 1'b1; aux_req = 1'b1;
    #1;
    check("ar_wait_clear_cpu_gnt", cpu_gnt, 1);
    $display("txn async reset done");
    step;
    cpu_req = 1'b0; aux_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsram_arbiter.md
# dsram_arbiter

The data-SRAM arbiter shares the single-port data SRAM between the CPU memory pipeline (port 0) and an auxiliary requester (port 1, e.g. an uncached/DMA engine). It resolves one access per cycle and drives the SRAM port. It routes the 1-cycle-latency read data back to the owner, and raises a stall request to the pipeline controller when the CPU loses arbitration. CPU has priority; a wait counter guarantees the auxiliary port forward progress.

## Interface
- MAX_WAIT, 4: consecutive denied aux cycles before aux is forced to win; legal range 1..15.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; kills CPU request and CPU read return this cycle
- cpu_req  in  1  CPU access request (en)
- cpu_wen  in  4  CPU byte write enables; 0 = read
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_gnt  out  1  CPU access issued to SRAM this cycle
- cpu_rvalid  out  1  CPU read data valid (cycle after grant)
- cpu_rdata  out  32  CPU read data
- cpu_stallreq  out  1  CPU requested but not granted; to ctrl stall logic
- aux_req, aux_wen[3:0], aux_addr[31:0], aux_wdata[31:0]  in  as CPU port
- aux_gnt, aux_rvalid  out  1 each; aux_rdata  out  32  as CPU port
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  SRAM byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- data_sram_rdata  in  32  SRAM read data, valid 1 cycle after en with wen=0

## Operation
- Effective CPU request: cpu_req & ~flush.
- Grant (combinational, same cycle):
  - force_aux = aux_req & (wait_cnt == MAX_WAIT).
  - aux_gnt = aux_req & (force_aux | ~cpu_req_eff).
  - cpu_gnt = cpu_req_eff & ~aux_gnt.
  - Never both grants at once.
- SRAM mux:
  - Winner's wen/addr/wdata drive the SRAM port; data_sram_en = cpu_gnt | aux_gnt.
  - With no grant, all SRAM outputs are 0.
- cpu_stallreq = cpu_req_eff & ~cpu_gnt.
- Wait counter wait_cnt (4 bits, registered):
  - 0 when aux_req=0 or aux_gnt=1.
  - Otherwise increments, saturating at MAX_WAIT.
- Read-return tag (registered): rd_owner ∈ {NONE, CPU, AUX}.
  - Next value: CPU if cpu_gnt & cpu_wen==0; AUX if aux_gnt & aux_wen==0; else NONE.
  - Writes never produce rvalid.
- Return path (cycle after grant):
  - cpu_rvalid = (rd_owner==CPU) & ~flush.
  - aux_rvalid = (rd_owner==AUX).
  - Both rdata outputs carry data_sram_rdata when their rvalid=1, else 0.
  - A flush in the return cycle drops the CPU read; the aux read is unaffected.
- The arbiter does not check address alignment or byte-enable legality; both are requester responsibilities.

## Timing
- Reset values: wait_cnt=0, rd_owner=NONE.
  - Hence cpu_rvalid, aux_rvalid, cpu_rdata and aux_rdata are 0.
  - Grant/SRAM outputs follow inputs combinationally.
- Reset asserted mid-access: an outstanding read return is discarded (rvalid stays 0); requesters must reissue.
- Latency:
  - Grant is 0 cycles after request.
  - Read data is returned exactly 1 cycle after grant.
  - Throughput is 1 access/cycle, including back-to-back reads to alternating owners.
- Requesters hold req/wen/addr/wdata stable until they see gnt; a request is consumed only in its gnt cycle.
- Starvation bound: aux waits at most MAX_WAIT cycles. On the forced cycle, the CPU stalls for exactly one cycle.
- Simultaneous events:
  - Flush with both requesting: aux wins and wait_cnt clears.
  - Flush on a return cycle blocks only cpu_rvalid.
  - Aux dropping its request clears wait_cnt the next cycle.

## Test plan
- Reset: assert rst asynchronously mid-cycle with rd_owner=CPU -> cpu_rvalid=0 immediately; wait_cnt=0; after release, idle -> data_sram_en=0.
- Solo CPU read then write: cpu_req, wen=0, addr=0x80001004 -> same cycle cpu_gnt=1, data_sram_addr=0x80001004. SRAM returns 0xDEADBEEF -> next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF. Then wen=4'b0011 write -> no rvalid.
- Contention, MAX_WAIT=4: cpu_req and aux_req held high continuously -> cpu_gnt for 4 cycles, aux_gnt on cycle 5 with cpu_stallreq=1, then the CPU wins for the next 4 cycles.
- Alternating reads: CPU read grant at cycle n, aux read grant at n+1 -> cpu_rvalid at n+1, aux_rvalid at n+2, data not crossed.
- Flush: CPU read granted at n, flush=1 at n+1 -> cpu_rvalid=0. Separately, flush=1 with cpu_req=1, aux_req=0 -> cpu_gnt=0, cpu_stallreq=0, data_sram_en=0.
- Aux drop: aux denied 3 cycles, then aux_req=0 for 1 cycle, then contention resumes -> aux waits a further full 4 cycles before its forced grant.
